// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: fetch stage for the 9-bit ISA core.
// Owns the architectural PC and sequences the steps FETCH -> WAIT -> EXEC
// against a synchronous instruction ROM.
// Optional performance counters are built when FETCH_PERF_CNT_EN is defined.
// Without that macro, cycle_count and instr_count read as zero and no counter
// flops exist.
module instr_fetch_unit #(
  parameter int          ADDR_W      = 10,
  parameter int          MEM_DEPTH   = 1024,
  parameter logic [31:0] START_PC    = 32'h0,
  parameter logic [8:0]  HALT_OPCODE = 9'h1FF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stall,
  input  logic [31:0]       next_pc,
  input  logic [8:0]        imem_rdata,
  output logic              imem_rd_en,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       current_pc,
  output logic [8:0]        instruction,
  output logic              instr_valid,
  output logic              done,
  output logic              pc_oob,
  output logic [31:0]       cycle_count,
  output logic [31:0]       instr_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_EXEC,
    S_HALT
  } state_t;

  // First byte address past the ROM; 33 bits so the product cannot overflow.
  localparam logic [32:0] PC_LIMIT = 33'(MEM_DEPTH) * 33'd4;

  state_t      state_q, state_d;
  logic [31:0] pc_d;
  logic [8:0]  instr_d;
  logic        done_d, oob_d;
  logic        pc_out_of_range;

  assign pc_out_of_range = ({1'b0, next_pc} >= PC_LIMIT);

  assign imem_rd_en  = (state_q == S_FETCH);
  assign imem_addr   = current_pc[ADDR_W+1:2];
  assign instr_valid = (state_q == S_EXEC);

  // State, PC, instruction and status registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      current_pc  <= '0;
      instruction <= '0;
      done        <= 1'b0;
      pc_oob      <= 1'b0;
    end else begin
      state_q     <= state_d;
      current_pc  <= pc_d;
      instruction <= instr_d;
      done        <= done_d;
      pc_oob      <= oob_d;
    end
  end

  // Next-state logic. In EXEC the checks are applied in this order:
  // stall, then halt opcode, then out-of-range, then advance.
  always_comb begin
    state_d = state_q;
    pc_d    = current_pc;
    instr_d = instruction;
    done_d  = done;
    oob_d   = pc_oob;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          pc_d    = START_PC;
          state_d = S_FETCH;
        end
      end
      S_FETCH: state_d = S_WAIT;
      S_WAIT: begin
        instr_d = imem_rdata;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        if (!stall) begin
          if (instruction == HALT_OPCODE) begin
            done_d  = 1'b1;
            state_d = S_HALT;
          end else if (pc_out_of_range) begin
            done_d  = 1'b1;
            oob_d   = 1'b1;
            state_d = S_HALT;
          end else begin
            pc_d    = next_pc;
            state_d = S_FETCH;
          end
        end
      end
      S_HALT: begin
        if (start) begin
          done_d  = 1'b0;
          oob_d   = 1'b0;
          pc_d    = START_PC;
          state_d = S_FETCH;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

`ifdef FETCH_PERF_CNT_EN
  logic load_start, retire, active;

  assign load_start = start && ((state_q == S_IDLE) || (state_q == S_HALT));
  assign active     = (state_q != S_IDLE) && (state_q != S_HALT);
  // An instruction retires both when it advances and when its next_pc is out of range.
  assign retire     = (state_q == S_EXEC) && !stall && (instruction != HALT_OPCODE);

  // Saturating performance counters, cleared on an accepted start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_count <= '0;
      instr_count <= '0;
    end else if (load_start) begin
      cycle_count <= '0;
      instr_count <= '0;
    end else begin
      if (active && (cycle_count != '1)) cycle_count <= cycle_count + 32'd1;
      if (retire && (instr_count != '1)) instr_count <= instr_count + 32'd1;
    end
  end
`else
  assign cycle_count = '0;
  assign instr_count = '0;
`endif

endmodule
